instr_cache_refill: RTL and testbench
=====================================

Name: instr_cache_refill

Overview:
- Line-refill engine upstream of the L1 instruction cache sets.
- On a cache miss it fetches one B-byte block from the next memory level, one 32-bit word per handshake beat.
- It assembles the words into a line-wide buffer, then pulses the ready strobe so the active set writes data and tag in that cycle.
- Also supplies a busy flag the pipeline uses to stall fetch.

Parameters:
B, 64, block size in bytes (power of two, >= 8); WORDS = B/4
A, 32, address width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
cache_miss  input  1  miss indication from the active cache set (combinational, same cycle as miss_addr)
miss_addr  input  A  fetch address that missed
flush  input  1  pipeline flush; abandons the current refill
mem_valid  input  1  memory returns the requested word this cycle
mem_rdata  input  32  returned word
mem_req  output  1  word request, held until mem_valid
mem_addr  output  A  word-aligned request address
rep_block  output  B*8  assembled line; word k at bits [32k+31:32k]
rep_ready  output  1  one-cycle strobe: rep_block valid, set may replace
refill_busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, FETCH, DONE. Registers: state, base (A bits), word_cnt ($clog2(WORDS) bits), abort flag, rep_block.
- Reset (any state, including mid-refill): state=IDLE, word_cnt=0, abort=0, base=0, rep_block=0. Outputs: mem_req=0, mem_addr=0, rep_ready=0, refill_busy=0.
- IDLE:
  - cache_miss=1 and flush=0: latch base = miss_addr with low $clog2(B) bits cleared, word_cnt=0, abort=0; next state FETCH.
  - cache_miss=1 and flush=1: stay in IDLE.
- FETCH:
  - mem_req=1.
  - mem_addr = base + (word_cnt<<2). Stable while waiting; low 2 bits always 0.
  - On mem_valid: rep_block[32*word_cnt +: 32] <= mem_rdata.
  - If word_cnt==WORDS-1: next state DONE. Else word_cnt increments.
- Exactly one outstanding request. A beat never aborts before mem_valid; memory may insert any number of wait cycles.
- Flush in FETCH:
  - Sets abort.
  - If mem_valid in the same cycle, or when the current beat later completes, go to IDLE. No further requests, no rep_ready.
  - word_cnt does not advance on the aborted beat.
- DONE:
  - Lasts exactly one cycle; next state IDLE.
  - rep_ready = (state==DONE) & ~flush & ~abort.
  - Flush in DONE suppresses rep_ready.
- Miss-to-strobe latency with zero-wait memory (mem_valid in the same cycle mem_req is high): miss seen in cycle 0 -> mem_req cycles 1..WORDS -> rep_ready in cycle WORDS+1. Each wait cycle adds 1.
- Back-to-back misses: IDLE may start a new refill in the cycle right after DONE if cache_miss is high. By then the set reflects the new line, so cache_miss is a real new miss.
- cache_miss and miss_addr are ignored outside IDLE. mem_valid is ignored outside FETCH.
- rep_block keeps its contents after DONE until overwritten by the next refill; it is not cleared between refills.
- base + offset never crosses a block boundary: the offset is < B and base is block-aligned, so no carry into tag bits.

Test Plan:
- Basic fill: B=64, miss_addr=0x0000_1234, zero-wait memory returning 0xA000_0000+k for word k -> mem_addr steps 0x1200, 0x1204 … 0x123C. rep_ready is a single pulse in cycle 17 after the miss. rep_block word 0 = 0xA000_0000, word 15 = 0xA000_000F.
- Wait states: memory delays each mem_valid by 3 cycles -> mem_addr held constant during waits, rep_ready at cycle 1+16*4. No duplicate or skipped words.
- Flush mid-refill: flush pulses while waiting on word 5 -> mem_req stays high until word 5 returns, then IDLE. No rep_ready; refill_busy falls the cycle after that beat.
- Flush in DONE: flush high in the DONE cycle -> rep_ready stays 0, state IDLE next cycle.
- Reset mid-refill: reset asserted during word 9 -> next cycle mem_req=0, refill_busy=0, rep_block=0. A subsequent miss refills from word 0.
- Back-to-back misses: second miss (0x0000_2000) presented in the cycle after DONE -> new refill starts immediately, with mem_addr=0x2000 one cycle later.

Source files
------------

// File: rtl/instr_cache_refill.sv
// instr_cache_refill
//   Line-refill engine sitting in front of the L1 instruction cache sets.
//   On a miss it fetches one B-byte block from the next memory level, one
//   32-bit word per request/valid handshake. Words are assembled into
//   rep_block. A one-cycle rep_ready strobe then lets the active set write
//   data and tag.
//
// Ports
//   clk, reset   : clock; synchronous active-high reset
//   cache_miss   : miss from the active set (only sampled in IDLE)
//   miss_addr    : address that missed
//   flush        : pipeline flush, abandons the refill in progress
//   mem_valid    : memory returns the requested word this cycle
//   mem_rdata    : returned word
//   mem_req      : word request, held until mem_valid
//   mem_addr     : word-aligned request address
//   rep_block    : assembled line, word k at bits [32k+31:32k]
//   rep_ready    : one-cycle strobe, rep_block may be written into the set
//   refill_busy  : engine not idle (fetch stall)
module instr_cache_refill #(
  parameter int B = 64,
  parameter int A = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cache_miss,
  input  logic [A-1:0]   miss_addr,
  input  logic           flush,
  input  logic           mem_valid,
  input  logic [31:0]    mem_rdata,
  output logic           mem_req,
  output logic [A-1:0]   mem_addr,
  output logic [B*8-1:0] rep_block,
  output logic           rep_ready,
  output logic           refill_busy
);

  localparam int WORDS = B / 4;
  localparam int CW    = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state, stateNext;
  logic [A-1:0]  base;
  logic [CW-1:0] wordCnt;
  logic          abort;
  logic          lastWord;
  logic          killBeat;

  assign lastWord    = (wordCnt == CW'(WORDS - 1));
  // A flush seen now or earlier in this refill ends it once the beat lands.
  assign killBeat    = flush | abort;
  assign refill_busy = (state != IDLE);

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    rep_ready = 1'b0;
    case (state)
      IDLE: begin
        if (cache_miss && !flush) stateNext = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        // base is block-aligned and the offset is < B, so no carry into tag bits.
        mem_addr = base + A'({wordCnt, 2'b00});
        if (mem_valid) begin
          if (killBeat)      stateNext = IDLE;
          else if (lastWord) stateNext = DONE;
        end
      end
      DONE: begin
        rep_ready = ~flush & ~abort;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      wordCnt   <= '0;
      abort     <= 1'b0;
      rep_block <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (cache_miss && !flush) begin
            base    <= miss_addr & ~A'(B - 1);
            wordCnt <= '0;
            abort   <= 1'b0;
          end
        end
        FETCH: begin
          if (flush) abort <= 1'b1;
          if (mem_valid) begin
            rep_block[32*wordCnt +: 32] <= mem_rdata;
            if (!killBeat && !lastWord) wordCnt <= wordCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for instr_cache_refill (B=64, A=32). Inputs are driven just
// after the rising edge; outputs are sampled on the falling edge.
module tb_instr_cache_refill;

  localparam int B = 64;
  localparam int A = 32;
  localparam int WORDS = B / 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cache_miss;
  logic [A-1:0]   miss_addr;
  logic           flush;
  logic           mem_valid;
  logic [31:0]    mem_rdata;
  logic           mem_req;
  logic [A-1:0]   mem_addr;
  logic [B*8-1:0] rep_block;
  logic           rep_ready;
  logic           refill_busy;

  int checks = 0;
  int failures = 0;

  instr_cache_refill #(.B(B), .A(A)) dut (
    .clk(clk), .reset(reset), .cache_miss(cache_miss), .miss_addr(miss_addr),
    .flush(flush), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .rep_block(rep_block),
    .rep_ready(rep_ready), .refill_busy(refill_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        fl;
    logic        mv;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eRdy;
    logic        eBusy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic setIn(input logic m, input logic [31:0] a, input logic f,
                       input logic v, input logic [31:0] d);
    cache_miss = m; miss_addr = a; flush = f; mem_valid = v; mem_rdata = d;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chkOut(input string nm, input logic eReq, input logic [31:0] eAddr,
                        input logic eRdy, input logic eBusy);
    chk({nm, "_req"}, 32'(mem_req), 32'(eReq));
    chk({nm, "_addr"}, mem_addr, eAddr);
    chk({nm, "_rdy"}, 32'(rep_ready), 32'(eRdy));
    chk({nm, "_busy"}, 32'(refill_busy), 32'(eBusy));
  endtask

  // Full refill: miss cycle, WORDS beats each preceded by 'waits' idle cycles,
  // then the DONE cycle (optionally flushed). Returns right after DONE.
  task automatic fill(input logic [31:0] addr, input int waits,
                      input logic [31:0] dbase, input bit flushDone);
    logic [31:0] base;
    base = addr & ~32'(B - 1);
    setIn(1'b1, addr, 1'b0, 1'b0, 32'h0); settle();
    chkOut("fill_miss", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < WORDS; k++) begin
      for (int w = 0; w < waits; w++) begin
        setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); settle();
        chkOut("fill_wait", 1'b1, base + 32'(4*k), 1'b0, 1'b1);
        tick();
      end
      setIn(1'b0, 32'h0, 1'b0, 1'b1, dbase + 32'(k)); settle();
      chkOut("fill_beat", 1'b1, base + 32'(4*k), 1'b0, 1'b1);
      tick();
    end
    setIn(1'b0, 32'h0, flushDone, 1'b0, 32'h0); settle();
    chkOut(flushDone ? "done_flush" : "done", 1'b0, 32'h0, !flushDone, 1'b1);
    tick();
    setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < WORDS; k++)
      chk("fill_word", rep_block[32*k +: 32], dbase + 32'(k));
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1234, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h5678, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b1, 32'h5640, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h11, 1'b1, 32'h5640, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h9999, 1'b0, 1'b0, 32'h0,  1'b1, 32'h5644, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h22, 1'b1, 32'h5644, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b1, 32'h5648, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h33, 1'b1, 32'h5648, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h44, 1'b0, 32'h0,    1'b0, 1'b0};

    reset = 1'b1;
    setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    settle();
    chkOut("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset_block_w0", rep_block[31:0], 32'h0);
    tick();

    // Table: flushed miss ignored, short refill, ignored miss in FETCH,
    // flush with same-cycle beat, mem_valid ignored in IDLE.
    for (int i = 0; i < 9; i++) begin
      setIn(vecs[i].miss, vecs[i].addr, vecs[i].fl, vecs[i].mv, vecs[i].rdata);
      settle();
      chkOut($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eRdy, vecs[i].eBusy);
      tick();
    end
    chk("vec_word0", rep_block[31:0], 32'h11);
    chk("vec_word1", rep_block[63:32], 32'h22);

    // Basic zero-wait fill, then back-to-back second miss right after DONE.
    fill(32'h0000_1234, 0, 32'hA000_0000, 1'b0);
    fill(32'h0000_2000, 0, 32'hB000_0000, 1'b0);
    // Three wait cycles per beat.
    fill(32'h0000_3333, 3, 32'hC000_0000, 1'b0);
    // Flush in DONE suppresses the strobe; engine is idle next cycle.
    fill(32'h0000_0040, 0, 32'hD000_0000, 1'b1);
    settle();
    chkOut("after_done_flush", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Flush while waiting on word 5: request held until the beat returns.
    setIn(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0); tick();
    for (int k = 0; k < 5; k++) begin
      setIn(1'b0, 32'h0, 1'b0, 1'b1, 32'h100 + 32'(k)); tick();
    end
    setIn(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); settle();
    chkOut("mid_flush", 1'b1, 32'h3014, 1'b0, 1'b1);
    tick();
    setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); settle();
    chkOut("mid_flush_wait", 1'b1, 32'h3014, 1'b0, 1'b1);
    tick();
    setIn(1'b0, 32'h0, 1'b0, 1'b1, 32'h105); settle();
    chkOut("mid_flush_beat", 1'b1, 32'h3014, 1'b0, 1'b1);
    tick();
    setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chkOut("mid_flush_idle", 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end

    // Reset during word 9, then a fresh refill starts at word 0.
    setIn(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0); tick();
    for (int k = 0; k < 9; k++) begin
      setIn(1'b0, 32'h0, 1'b0, 1'b1, 32'h200 + 32'(k)); tick();
    end
    setIn(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1; settle();
    chkOut("rst_mid_pre", 1'b1, 32'h4024, 1'b0, 1'b1);
    tick();
    reset = 1'b0; settle();
    chkOut("rst_mid_post", 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < WORDS; k++)
      chk("rst_mid_block", rep_block[32*k +: 32], 32'h0);
    tick();
    fill(32'h0000_4100, 1, 32'hE000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
